// File: rtl/pc_fetch_if.sv
// IF-stage fetch bundle: hazard/redirect/trap inputs, imem handshake,
// PC, IF valid, flush, misaligned pulse and retired-fetch counter.
interface pc_fetch_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
);
  logic                  stall_i;
  logic                  redirect_valid_i;
  logic [ADDR_WIDTH-1:0] redirect_target_i;
  logic                  trap_valid_i;
  logic [ADDR_WIDTH-1:0] trap_vector_i;
  logic                  imem_ready_i;
  logic                  imem_req_o;
  logic [ADDR_WIDTH-1:0] imem_addr_o;
  logic [ADDR_WIDTH-1:0] pc_o;
  logic                  if_valid_o;
  logic                  flush_o;
  logic                  misaligned_o;
  logic [CNT_WIDTH-1:0]  fetch_count_o;

  modport master (
    input  stall_i, redirect_valid_i, redirect_target_i,
    input  trap_valid_i, trap_vector_i, imem_ready_i,
    output imem_req_o, imem_addr_o, pc_o, if_valid_o,
    output flush_o, misaligned_o, fetch_count_o
  );

  modport slave (
    output stall_i, redirect_valid_i, redirect_target_i,
    output trap_valid_i, trap_vector_i, imem_ready_i,
    input  imem_req_o, imem_addr_o, pc_o, if_valid_o,
    input  flush_o, misaligned_o, fetch_count_o
  );
endinterface

// File: rtl/pc_fetch_controller.sv
// IF-stage PC sequencer: clk, rst (sync, active-high), bus (master).
// Picks trap/redirect/stall/sequential PC, holds addr while imem busy.
module pc_fetch_controller #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                    CNT_WIDTH    = 32
) (
  input logic        clk,
  input logic        rst,
  pc_fetch_if.master bus
);

  typedef enum logic [1:0] {
    BOOT, RUN, WAIT, DRAIN
  } state_t;

  typedef struct packed {
    logic                  valid;
    logic                  trap;
    logic [ADDR_WIDTH-1:0] tgt;
  } pend_t;

  state_t                state_q;
  pend_t                 pend_q;
  pend_t                 pend_n;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic                  req_q;
  logic [CNT_WIDTH-1:0]  cnt_q;

  logic                  take;
  logic                  accept;
  logic                  ready;
  logic [ADDR_WIDTH-1:0] sel_tgt;
  logic [ADDR_WIDTH-1:0] tgt_al;
  logic                  if_valid;

  assign ready   = bus.imem_ready_i;
  assign take    = bus.trap_valid_i | bus.redirect_valid_i;
  assign sel_tgt = bus.trap_valid_i ? bus.trap_vector_i
                                    : bus.redirect_target_i;
  assign tgt_al  = {sel_tgt[ADDR_WIDTH-1:2], 2'b00};

  always_comb begin
    accept   = take;
    if_valid = 1'b0;
    pend_n   = pend_q;
    unique case (state_q)
      BOOT: ;
      RUN, WAIT:
        if_valid = ~take & ready & ~bus.stall_i;
      DRAIN:
        // a pending trap is never displaced by a redirect
        accept = bus.trap_valid_i |
                 (bus.redirect_valid_i &
                  ~(pend_q.valid & pend_q.trap));
      default: ;
    endcase
    if (accept) begin
      pend_n = '{valid: 1'b1,
                 trap:  bus.trap_valid_i,
                 tgt:   tgt_al};
    end
  end

  assign bus.if_valid_o    = if_valid;
  assign bus.flush_o       = accept;
  assign bus.misaligned_o  = accept & (|sel_tgt[1:0]);
  assign bus.imem_req_o    = req_q;
  assign bus.imem_addr_o   = pc_q;
  assign bus.pc_o          = pc_q;
  assign bus.fetch_count_o = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      req_q   <= 1'b0;
      cnt_q   <= '0;
      pend_q  <= '0;
    end else begin
      req_q <= 1'b1;
      if (if_valid) cnt_q <= cnt_q + CNT_WIDTH'(1);
      unique case (state_q)
        BOOT: begin
          state_q <= RUN;
          if (take) pc_q <= tgt_al;
        end
        RUN, WAIT: begin
          unique case (1'b1)
            take & ready: begin
              pc_q    <= tgt_al;
              state_q <= RUN;
            end
            take & ~ready: begin
              pend_q  <= pend_n;
              state_q <= DRAIN;
            end
            ~take & ready: begin
              state_q <= RUN;
              if (~bus.stall_i)
                pc_q <= pc_q + ADDR_WIDTH'(4);
            end
            ~take & ~ready:
              state_q <= WAIT;
            default: ;
          endcase
        end
        DRAIN: begin
          if (ready) begin
            // returned word is dropped; resume at target
            pc_q    <= pend_n.tgt;
            pend_q  <= '0;
            state_q <= RUN;
          end else begin
            pend_q <= pend_n;
          end
        end
        default: state_q <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_controller.sv
// Bench for pc_fetch_controller: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_pc_fetch_controller;
  localparam int AW = 32;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_fetch_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();
  pc_fetch_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus_w ();

  pc_fetch_controller #(
    .ADDR_WIDTH(AW), .RESET_VECTOR(32'h0), .CNT_WIDTH(CW)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  pc_fetch_controller #(
    .ADDR_WIDTH(AW), .RESET_VECTOR(32'hFFFF_FFF8), .CNT_WIDTH(CW)
  ) dut_w (.clk(clk), .rst(rst), .bus(bus_w));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    bit          trap;
  } pend_t;

  bit          m_boot;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  pend_t       pend_q[$];

  bit          nx_boot;
  logic [31:0] nx_pc;
  logic [31:0] nx_cnt;
  pend_t       nx_q[$];

  bit e_req, e_ifv, e_flush, e_mis;

  task automatic apply(input bit st, input bit rv,
                       input logic [31:0] rt, input bit tv,
                       input logic [31:0] tt, input bit rdy);
    logic [31:0] tgt;
    bit take, acc;
    bus.stall_i           = st;
    bus.redirect_valid_i  = rv;
    bus.redirect_target_i = rt;
    bus.trap_valid_i      = tv;
    bus.trap_vector_i     = tt;
    bus.imem_ready_i      = rdy;
    #1;
    tgt = tv ? tt : rt;
    take = tv | rv;
    e_req = !m_boot;
    e_ifv = 0;
    nx_boot = m_boot;
    nx_pc = m_pc;
    nx_cnt = m_cnt;
    nx_q = pend_q;
    if (m_boot) begin
      acc = take;
      nx_boot = 0;
      if (take) nx_pc = tgt & ~32'h3;
    end else if (pend_q.size() > 0) begin
      acc = tv || (rv && !pend_q[0].trap);
      if (acc) begin
        nx_q.delete();
        nx_q.push_back('{tgt & ~32'h3, tv});
      end
      if (rdy) begin
        nx_pc = nx_q[0].addr;
        nx_q.delete();
      end
    end else begin
      acc = take;
      e_ifv = !take && rdy && !st;
      if (take && rdy) nx_pc = tgt & ~32'h3;
      else if (take) nx_q.push_back('{tgt & ~32'h3, tv});
      else if (e_ifv) nx_pc = m_pc + 32'd4;
    end
    if (e_ifv) nx_cnt = m_cnt + 32'd1;
    e_flush = acc;
    e_mis = acc && (tgt[1:0] != 2'b00);
  endtask

  task automatic advance();
    @(posedge clk);
    m_boot = nx_boot;
    m_pc = nx_pc;
    m_cnt = nx_cnt;
    pend_q = nx_q;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.stall_i = 0;
    bus.redirect_valid_i = 0;
    bus.redirect_target_i = '0;
    bus.trap_valid_i = 0;
    bus.trap_vector_i = '0;
    bus.imem_ready_i = 1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_boot = 1;
    m_pc = 32'h0;
    m_cnt = 32'h0;
    pend_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    apply(0, 0, 0, 0, 0, 1);
    checks++;
    if (bus.imem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_req: got %b exp 0", bus.imem_req_o);
    end
    checks++;
    if (bus.pc_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_pc: got %h exp 0", bus.pc_o);
    end
    checks++;
    if (bus.fetch_count_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_cnt: got %h exp 0", bus.fetch_count_o);
    end
    checks++;
    if ({bus.if_valid_o, bus.flush_o, bus.misaligned_o} !== 3'b000) begin
      errors++;
      $display("FAIL reset_pulses: got %b%b%b exp 000",
               bus.if_valid_o, bus.flush_o, bus.misaligned_o);
    end
    advance();
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) begin
      apply(0, 0, 0, 0, 0, 1);
      checks++;
      if (bus.pc_o !== 32'(4 * i) || bus.if_valid_o !== 1'b1) begin
        errors++;
        $display("FAIL seq_pc%0d: got pc %h v %b exp pc %h v 1",
                 i, bus.pc_o, bus.if_valid_o, 32'(4 * i));
      end
      checks++;
      if (bus.imem_addr_o !== bus.pc_o || bus.imem_req_o !== 1'b1) begin
        errors++;
        $display("FAIL seq_addr%0d: got addr %h req %b exp %h 1",
                 i, bus.imem_addr_o, bus.imem_req_o, bus.pc_o);
      end
      advance();
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 2; i++) begin
      apply(1, 0, 0, 0, 0, 1);
      checks++;
      if (bus.pc_o !== 32'h10 || bus.if_valid_o !== 1'b0 ||
          bus.fetch_count_o !== 32'd4) begin
        errors++;
        $display("FAIL stall_hold%0d: got pc %h v %b cnt %0d exp 10 0 4",
                 i, bus.pc_o, bus.if_valid_o, bus.fetch_count_o);
      end
      advance();
    end
    apply(0, 0, 0, 0, 0, 1);
    checks++;
    if (bus.pc_o !== 32'h10 || bus.if_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: got pc %h v %b exp 10 1",
               bus.pc_o, bus.if_valid_o);
    end
    advance();
    checks++;
    if (bus.fetch_count_o !== 32'd5 || bus.pc_o !== 32'h14) begin
      errors++;
      $display("FAIL stall_count: got cnt %0d pc %h exp 5 14",
               bus.fetch_count_o, bus.pc_o);
    end
  endtask

  task automatic test_redirect();
    apply(0, 1, 32'h100, 0, 0, 1);
    checks++;
    if (bus.flush_o !== 1'b1 || bus.if_valid_o !== 1'b0 ||
        bus.misaligned_o !== 1'b0) begin
      errors++;
      $display("FAIL redir_flush: got f %b v %b m %b exp 1 0 0",
               bus.flush_o, bus.if_valid_o, bus.misaligned_o);
    end
    advance();
    checks++;
    if (bus.pc_o !== 32'h100) begin
      errors++;
      $display("FAIL redir_pc: got %h exp 100", bus.pc_o);
    end
    apply(0, 1, 32'h102, 0, 0, 1);
    checks++;
    if (bus.misaligned_o !== 1'b1 || bus.flush_o !== 1'b1) begin
      errors++;
      $display("FAIL redir_mis: got m %b f %b exp 1 1",
               bus.misaligned_o, bus.flush_o);
    end
    advance();
    checks++;
    if (bus.pc_o !== 32'h100) begin
      errors++;
      $display("FAIL redir_align: got %h exp 100", bus.pc_o);
    end
  endtask

  task automatic test_drain();
    apply(0, 1, 32'h20, 0, 0, 1);
    advance();
    apply(0, 0, 0, 0, 0, 0);
    advance();
    apply(0, 1, 32'h80, 0, 0, 0);
    checks++;
    if (bus.flush_o !== 1'b1 || bus.imem_addr_o !== 32'h20) begin
      errors++;
      $display("FAIL drain_latch: got f %b addr %h exp 1 20",
               bus.flush_o, bus.imem_addr_o);
    end
    advance();
    apply(0, 0, 0, 1, 32'h200, 0);
    checks++;
    if (bus.imem_addr_o !== 32'h20 || bus.imem_req_o !== 1'b1 ||
        bus.if_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL drain_hold: got addr %h req %b v %b exp 20 1 0",
               bus.imem_addr_o, bus.imem_req_o, bus.if_valid_o);
    end
    advance();
    apply(0, 0, 0, 0, 0, 1);
    checks++;
    if (bus.if_valid_o !== 1'b0 || bus.imem_addr_o !== 32'h20) begin
      errors++;
      $display("FAIL drain_drop: got v %b addr %h exp 0 20",
               bus.if_valid_o, bus.imem_addr_o);
    end
    advance();
    checks++;
    if (bus.pc_o !== 32'h200) begin
      errors++;
      $display("FAIL drain_trap_pc: got %h exp 200", bus.pc_o);
    end
    apply(0, 0, 0, 1, 32'h300, 0);
    advance();
    apply(1, 1, 32'h401, 0, 0, 0);
    checks++;
    if (bus.misaligned_o !== 1'b0 || bus.imem_addr_o !== 32'h200) begin
      errors++;
      $display("FAIL drain_ignore: got m %b addr %h exp 0 200",
               bus.misaligned_o, bus.imem_addr_o);
    end
    advance();
    apply(1, 0, 0, 0, 0, 1);
    advance();
    checks++;
    if (bus.pc_o !== 32'h300) begin
      errors++;
      $display("FAIL drain_keep_trap: got %h exp 300", bus.pc_o);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc;
    do_reset();
    apply(0, 0, 0, 0, 0, 1);
    checks++;
    if (bus_w.imem_req_o !== 1'b0 || bus_w.pc_o !== 32'hFFFF_FFF8) begin
      errors++;
      $display("FAIL wrap_boot: got req %b pc %h exp 0 fffffff8",
               bus_w.imem_req_o, bus_w.pc_o);
    end
    advance();
    for (int i = 0; i < 3; i++) begin
      exp_pc = 32'hFFFF_FFF8 + 32'(4 * i);
      apply(0, 0, 0, 0, 0, 1);
      checks++;
      if (bus_w.pc_o !== exp_pc || bus_w.if_valid_o !== 1'b1) begin
        errors++;
        $display("FAIL wrap_pc%0d: got pc %h v %b exp %h 1",
                 i, bus_w.pc_o, bus_w.if_valid_o, exp_pc);
      end
      advance();
    end
  endtask

  task automatic test_reset_drain();
    apply(0, 1, 32'h500, 0, 0, 0);
    advance();
    apply(0, 0, 0, 1, 32'h600, 0);
    advance();
    do_reset();
    checks++;
    if (bus.pc_o !== 32'h0 || bus.imem_req_o !== 1'b0 ||
        bus.fetch_count_o !== 32'h0) begin
      errors++;
      $display("FAIL rstdrain_state: got pc %h req %b cnt %0d exp 0 0 0",
               bus.pc_o, bus.imem_req_o, bus.fetch_count_o);
    end
    apply(0, 0, 0, 0, 0, 1);
    checks++;
    if (bus.if_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL rstdrain_boot: got v %b exp 0", bus.if_valid_o);
    end
    advance();
    apply(0, 0, 0, 0, 0, 1);
    checks++;
    if (bus.pc_o !== 32'h0 || bus.if_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL rstdrain_fetch: got pc %h v %b exp 0 1",
               bus.pc_o, bus.if_valid_o);
    end
    advance();
    checks++;
    if (bus.pc_o !== 32'h4) begin
      errors++;
      $display("FAIL rstdrain_next: got %h exp 4", bus.pc_o);
    end
  endtask

  task automatic test_random();
    bit st, rv, tv, rdy;
    logic [31:0] rt, tt;
    for (int i = 0; i < 400; i++) begin
      st  = ($urandom_range(0, 3) == 0);
      rv  = ($urandom_range(0, 4) == 0);
      tv  = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      rt  = $urandom;
      tt  = $urandom;
      apply(st, rv, rt, tv, tt, rdy);
      checks++;
      if (bus.pc_o !== m_pc || bus.imem_addr_o !== m_pc) begin
        errors++;
        $display("FAIL rnd_pc@%0d: got pc %h addr %h exp %h",
                 i, bus.pc_o, bus.imem_addr_o, m_pc);
      end
      checks++;
      if (bus.imem_req_o !== e_req) begin
        errors++;
        $display("FAIL rnd_req@%0d: got %b exp %b",
                 i, bus.imem_req_o, e_req);
      end
      checks++;
      if (bus.if_valid_o !== e_ifv) begin
        errors++;
        $display("FAIL rnd_valid@%0d: got %b exp %b",
                 i, bus.if_valid_o, e_ifv);
      end
      checks++;
      if (bus.flush_o !== e_flush) begin
        errors++;
        $display("FAIL rnd_flush@%0d: got %b exp %b",
                 i, bus.flush_o, e_flush);
      end
      checks++;
      if (bus.misaligned_o !== e_mis) begin
        errors++;
        $display("FAIL rnd_mis@%0d: got %b exp %b",
                 i, bus.misaligned_o, e_mis);
      end
      checks++;
      if (bus.fetch_count_o !== m_cnt) begin
        errors++;
        $display("FAIL rnd_cnt@%0d: got %0d exp %0d",
                 i, bus.fetch_count_o, m_cnt);
      end
      advance();
    end
  endtask

  initial begin
    bus_w.stall_i = 0;
    bus_w.redirect_valid_i = 0;
    bus_w.redirect_target_i = '0;
    bus_w.trap_valid_i = 0;
    bus_w.trap_vector_i = '0;
    bus_w.imem_ready_i = 1;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_drain();
    test_wrap();
    test_reset_drain();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
